// File: rtl/panel_pkg.sv
// Shared types and constants for the 32x32 1/16-scan panel controller.
package panel_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} panel_state_e;

  localparam int PANEL_ROWS_HALF = 16;
  localparam int PANEL_COL_W     = 5;
  localparam int PANEL_ROW_W     = 4;
  localparam int NUM_CH          = 6;

  // Channel order is R0,G0,B0,R1,G1,B1 with R0 in the most significant field.
  function automatic int fld_lsb(input int ch, input int bits);
    return (NUM_CH - 1 - ch) * bits;
  endfunction

  function automatic int fld_msb(input int ch, input int bits);
    return fld_lsb(ch, bits) + bits - 1;
  endfunction

endpackage

// File: rtl/panel_bcm_timer.sv
// Per-plane display timer: counts DISP_BASE<<plane cycles and holds OE low
// for the brightness-scaled leading part of that window.
module panel_bcm_timer
  import panel_pkg::*;
#(
  parameter int DISP_BASE = 8,
  parameter int PW        = 2,
  parameter int CW        = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          active,
  input  logic [PW-1:0] plane,
  input  logic [7:0]    brightness,
  output logic          oe_n,
  output logic          done
);

  localparam int PRW = CW + 9;

  logic [CW-1:0]  cnt, on_rem, len, on_len;
  logic [PRW-1:0] prod;

  always_comb begin
    len    = CW'(DISP_BASE) << plane;
    prod   = PRW'(len) * PRW'({1'b0, brightness} + 9'd1);
    on_len = CW'(prod >> 8);
  end

  assign done = active && (cnt == '0);

  // oe_n is registered one step ahead so the pin flop itself drives the panel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      on_rem <= '0;
      oe_n   <= 1'b1;
    end else if (load) begin
      cnt    <= len - CW'(1);
      on_rem <= on_len;
      oe_n   <= (on_len == '0);
    end else if (active && cnt != '0) begin
      cnt    <= cnt - CW'(1);
      on_rem <= (on_rem != '0) ? on_rem - CW'(1) : '0;
      oe_n   <= !(on_rem > CW'(1));
    end else begin
      oe_n   <= 1'b1;
    end
  end

endmodule

// File: rtl/panel_scan_ctrl.sv
// BCM scan controller for a 32x32 1/16-scan RGB panel.
// Optional PANEL_BRIGHTNESS_EN adds a global brightness input scaling OE on-time.
module panel_scan_ctrl
  import panel_pkg::*;
#(
  parameter int BITS      = 4,
  parameter int COLS      = 32,
  parameter int DISP_BASE = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enable,
`ifdef PANEL_BRIGHTNESS_EN
  input  logic [7:0]                         brightness,
`endif
  output logic                               fb_rd_en,
  output logic [PANEL_ROW_W+PANEL_COL_W-1:0] fb_rd_addr,
  input  logic [NUM_CH*BITS-1:0]             fb_rdata,
  output logic                               PANEL_R0,
  output logic                               PANEL_G0,
  output logic                               PANEL_B0,
  output logic                               PANEL_R1,
  output logic                               PANEL_G1,
  output logic                               PANEL_B1,
  output logic                               PANEL_A,
  output logic                               PANEL_B,
  output logic                               PANEL_C,
  output logic                               PANEL_D,
  output logic                               PANEL_CLK,
  output logic                               PANEL_STB,
  output logic                               PANEL_OE,
  output logic                               frame_done
);

  localparam int PW     = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int CW     = $clog2(DISP_BASE) + BITS;
  localparam int KW     = $clog2(2*COLS + 2);
  localparam int RD_LAT = 1;
  localparam logic [KW-1:0]          K_LAST    = KW'(2*COLS + 1);
  localparam logic [KW-1:0]          K_RD_END  = KW'(2*COLS);
  localparam logic [PW-1:0]          PLANE_MAX = PW'(BITS - 1);
  localparam logic [PANEL_ROW_W-1:0] ROW_MAX   = PANEL_ROW_W'(PANEL_ROWS_HALF - 1);

  panel_state_e           state_q, state_d;
  logic [PANEL_ROW_W-1:0] row_q, row_d;
  logic [PW-1:0]          plane_q, plane_d;
  logic [KW-1:0]          k_q, k_d;
  logic                   wrap_d;
  logic                   tmr_done, tmr_oe_n;
  logic [7:0]             br_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      plane_q <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      plane_q <= plane_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    plane_d = plane_q;
    k_d     = k_q;
    wrap_d  = 1'b0;
    case (state_q)
      IDLE: if (enable) begin
        state_d = SHIFT;
        row_d   = '0;
        plane_d = '0;
        k_d     = '0;
      end
      SHIFT: begin
        if (k_q == K_LAST) state_d = LATCH;
        else               k_d     = k_q + KW'(1);
      end
      LATCH: state_d = DISPLAY;
      DISPLAY: if (tmr_done) begin
        k_d = '0;
        if (plane_q == PLANE_MAX) begin
          plane_d = '0;
          row_d   = row_q + PANEL_ROW_W'(1);
          wrap_d  = (row_q == ROW_MAX);
        end else begin
          plane_d = plane_q + PW'(1);
        end
        if (enable) begin
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
          row_d   = '0;
          plane_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef PANEL_BRIGHTNESS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        br_q <= '0;
    else if ((state_q == IDLE && enable) || wrap_d) br_q <= brightness;
  end
`else
  assign br_q = 8'hFF;
`endif

  panel_bcm_timer #(
    .DISP_BASE (DISP_BASE),
    .PW        (PW),
    .CW        (CW)
  ) u_bcm (
    .clk        (clk),
    .rst        (rst),
    .load       (state_q == LATCH),
    .active     (state_q == DISPLAY),
    .plane      (plane_q),
    .brightness (br_q),
    .oe_n       (tmr_oe_n),
    .done       (tmr_done)
  );

  // Pins are registered from next-state values, so the pin timeline in a
  // cycle matches the controller state of that same cycle.
  logic [NUM_CH-1:0]                     rgb_q, rgb_d;
  logic [NUM_CH-1:0][BITS-1:0]           fld;
  logic [RD_LAT:0]                       vld_pipe;
  logic [PANEL_ROW_W+PANEL_COL_W-1:0]    rd_addr_q;
  logic [PANEL_ROW_W-1:0]                row_pin_q;
  logic                                  sclk_q, stb_q, fdone_q;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    assign fld[ch]   = fb_rdata[fld_msb(ch, BITS):fld_lsb(ch, BITS)];
    assign rgb_d[ch] = fld[ch][plane_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      rd_addr_q <= '0;
      rgb_q     <= '0;
      sclk_q    <= 1'b0;
      stb_q     <= 1'b0;
      row_pin_q <= '0;
      fdone_q   <= 1'b0;
    end else begin
      vld_pipe  <= {vld_pipe[RD_LAT-1:0],
                    (state_d == SHIFT) && !k_d[0] && (k_d < K_RD_END)};
      rd_addr_q <= {row_d, PANEL_COL_W'(k_d >> 1)};
      if (vld_pipe[RD_LAT]) rgb_q <= rgb_d;
      sclk_q    <= (state_d == SHIFT) && k_d[0] && (k_d >= KW'(3));
      stb_q     <= (state_d == LATCH);
      if (state_d == LATCH) row_pin_q <= row_d;
      fdone_q   <= wrap_d;
    end
  end

  assign fb_rd_en   = vld_pipe[0];
  assign fb_rd_addr = rd_addr_q;
  assign PANEL_R0   = rgb_q[0];
  assign PANEL_G0   = rgb_q[1];
  assign PANEL_B0   = rgb_q[2];
  assign PANEL_R1   = rgb_q[3];
  assign PANEL_G1   = rgb_q[4];
  assign PANEL_B1   = rgb_q[5];
  assign PANEL_A    = row_pin_q[0];
  assign PANEL_B    = row_pin_q[1];
  assign PANEL_C    = row_pin_q[2];
  assign PANEL_D    = row_pin_q[3];
  assign PANEL_CLK  = sclk_q;
  assign PANEL_STB  = stb_q;
  assign PANEL_OE   = tmr_oe_n;
  assign frame_done = fdone_q;

endmodule

// File: tb/tb_panel_scan_ctrl.sv
// Bench for panel_scan_ctrl: random framebuffer, per-(row,plane) pin timeline model.
module tb_panel_scan_ctrl;

  localparam int BITS = 4, COLS = 32, DISP_BASE = 8, W = 6*BITS;

  logic clk = 1'b0;
  logic rst, enable;
`ifdef PANEL_BRIGHTNESS_EN
  logic [7:0] brightness;
`endif
  logic         fb_rd_en;
  logic [8:0]   fb_rd_addr;
  logic [W-1:0] fb_rdata;
  logic PANEL_R0, PANEL_G0, PANEL_B0, PANEL_R1, PANEL_G1, PANEL_B1;
  logic PANEL_A, PANEL_B, PANEL_C, PANEL_D, PANEL_CLK, PANEL_STB, PANEL_OE;
  logic frame_done;
  logic [5:0] rgb;
  logic [3:0] rowpins;
  logic [W-1:0] fb_mem [512];
  int errors = 0, checks = 0;

  assign rgb     = {PANEL_R0, PANEL_G0, PANEL_B0, PANEL_R1, PANEL_G1, PANEL_B1};
  assign rowpins = {PANEL_D, PANEL_C, PANEL_B, PANEL_A};

  always #5 clk = ~clk;

  panel_scan_ctrl #(.BITS(BITS), .COLS(COLS), .DISP_BASE(DISP_BASE)) dut (
    .clk(clk), .rst(rst), .enable(enable),
`ifdef PANEL_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .fb_rd_en(fb_rd_en), .fb_rd_addr(fb_rd_addr), .fb_rdata(fb_rdata),
    .PANEL_R0(PANEL_R0), .PANEL_G0(PANEL_G0), .PANEL_B0(PANEL_B0),
    .PANEL_R1(PANEL_R1), .PANEL_G1(PANEL_G1), .PANEL_B1(PANEL_B1),
    .PANEL_A(PANEL_A), .PANEL_B(PANEL_B), .PANEL_C(PANEL_C), .PANEL_D(PANEL_D),
    .PANEL_CLK(PANEL_CLK), .PANEL_STB(PANEL_STB), .PANEL_OE(PANEL_OE),
    .frame_done(frame_done)
  );

  // Synchronous RAM: data only meaningful the cycle after a read strobe.
  always @(posedge clk) fb_rdata <= fb_rd_en ? fb_mem[fb_rd_addr] : W'($urandom);

  function automatic int disp_len(input int plane);
    return DISP_BASE << plane;
  endfunction

  function automatic int on_time(input int plane);
`ifdef PANEL_BRIGHTNESS_EN
    return (disp_len(plane) * (int'(brightness) + 1)) >> 8;
`else
    return disp_len(plane);
`endif
  endfunction

  // Bits presented for (row, col, plane), ordered as rgb = {R0,G0,B0,R1,G1,B1}.
  function automatic logic [5:0] exp_bits(input int row, input int col, input int plane);
    logic [W-1:0] w;
    logic [5:0] r;
    w = fb_mem[row*32 + col];
    for (int j = 0; j < 6; j++) r[j] = w[j*BITS + plane];
    return r;
  endfunction

  task automatic fill_fb(input bit zero);
    for (int i = 0; i < 512; i++) fb_mem[i] = zero ? '0 : W'($urandom);
  endtask

  task automatic do_reset;
    rst = 1'b1; enable = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_scan(output bit ok);
    enable = 1'b1; ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fb_rd_en === 1'b1) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL start_scan: fb_rd_en got 0 within 10 cycles, want 1");
    end
  endtask

  // Called on the negedge of the first SHIFT cycle; returns on the next one.
  task automatic run_period(input int row, input int plane, input bit exp_fd, input int drop_at);
    int d, on, n, rises, rd_bad, clk_bad, data_bad, stb_bad, row_bad, oe_bad, fd_bad;
    bit e_rd, e_clk, e_stb, e_oe, e_fd;
    logic [5:0] prev_rgb, ex;
    logic prev_clk;
    d = disp_len(plane); on = on_time(plane); n = 2*COLS + 3 + d;
    rises = 0; rd_bad = 0; clk_bad = 0; data_bad = 0; stb_bad = 0; row_bad = 0; oe_bad = 0; fd_bad = 0;
    prev_rgb = rgb; prev_clk = 1'b0;
    for (int k = 0; k < n; k++) begin
      e_rd  = (k < 2*COLS) && (k % 2 == 0);
      e_clk = (k < 2*COLS + 2) && (k % 2 == 1) && (k >= 3);
      e_stb = (k == 2*COLS + 2);
      e_oe  = !(k >= 2*COLS + 3 && k < 2*COLS + 3 + on);
      e_fd  = exp_fd && (k == 0);
      if (fb_rd_en !== e_rd) rd_bad++;
      else if (e_rd && fb_rd_addr !== 9'(row*32 + k/2)) rd_bad++;
      if (PANEL_CLK !== e_clk) clk_bad++;
      if (PANEL_CLK === 1'b1 && prev_clk === 1'b0) begin
        if (rises < COLS) begin
          ex = exp_bits(row, rises, plane);
          if (rgb !== ex || prev_rgb !== ex) data_bad++;
        end
        rises++;
      end
      if (PANEL_STB !== e_stb) stb_bad++;
      if (e_stb && rowpins !== 4'(row)) row_bad++;
      if (PANEL_OE !== e_oe) oe_bad++;
      if (frame_done !== e_fd) fd_bad++;
      prev_clk = PANEL_CLK; prev_rgb = rgb;
      if (k == drop_at) enable = 1'b0;
      @(negedge clk);
    end
    checks += 8;
    if (rd_bad   != 0) begin errors++; $display("FAIL r%0d p%0d fb_read: got %0d bad cycles, want 0", row, plane, rd_bad); end
    if (rises != COLS) begin errors++; $display("FAIL r%0d p%0d clk_rises: got %0d, want %0d", row, plane, rises, COLS); end
    if (clk_bad  != 0) begin errors++; $display("FAIL r%0d p%0d clk_shape: got %0d bad cycles, want 0", row, plane, clk_bad); end
    if (data_bad != 0) begin errors++; $display("FAIL r%0d p%0d shift_data: got %0d bad columns, want 0", row, plane, data_bad); end
    if (stb_bad  != 0) begin errors++; $display("FAIL r%0d p%0d stb: got %0d bad cycles, want 0", row, plane, stb_bad); end
    if (row_bad  != 0) begin errors++; $display("FAIL r%0d p%0d row_addr: got %0d at latch, want %0d", row, plane, rowpins, row); end
    if (oe_bad   != 0) begin errors++; $display("FAIL r%0d p%0d oe: got %0d bad cycles, want 0 (on=%0d)", row, plane, oe_bad, on); end
    if (fd_bad   != 0) begin errors++; $display("FAIL r%0d p%0d frame_done: got %0d bad cycles, want 0", row, plane, fd_bad); end
  endtask

  task automatic check_idle(input string name, input int cycles);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      if (fb_rd_en !== 1'b0 || PANEL_OE !== 1'b1 || PANEL_CLK !== 1'b0 ||
          PANEL_STB !== 1'b0 || frame_done !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL %s: got %0d non-idle cycles, want 0", name, bad); end
  endtask

  task automatic test_reset;
    rst = 1'b1; enable = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({fb_rd_en, PANEL_CLK, PANEL_STB, rgb, rowpins, frame_done} !== '0) begin
      errors++;
      $display("FAIL reset_pins: got %b, want 0", {fb_rd_en, PANEL_CLK, PANEL_STB, rgb, rowpins, frame_done});
    end
    checks++;
    if (PANEL_OE !== 1'b1) begin errors++; $display("FAIL reset_oe: got %b, want 1", PANEL_OE); end
    rst = 1'b0;
    @(negedge clk);
    check_idle("idle_after_reset", 20);
  endtask

  task automatic test_single_col;
    bit ok;
    do_reset;
    fill_fb(1'b1);
    fb_mem[5] = W'(1) << (5*BITS);
    start_scan(ok);
    if (ok) run_period(0, 0, 1'b0, -1);
  endtask

  task automatic test_free_run;
    bit ok;
    do_reset;
    fill_fb(1'b0);
    start_scan(ok);
    if (ok)
      for (int i = 0; i <= 16*BITS; i++)
        run_period((i / BITS) % 16, i % BITS, i == 16*BITS, -1);
  endtask

  task automatic test_enable_drop;
    bit ok;
    do_reset;
    fill_fb(1'b0);
    start_scan(ok);
    if (ok) begin
      run_period(0, 0, 1'b0, -1);
      run_period(0, 1, 1'b0, -1);
      run_period(0, 2, 1'b0, 2*COLS + 3 + int'($urandom_range(0, 30)));
      check_idle("idle_after_drop", 30);
    end
  endtask

  task automatic test_reset_mid_shift;
    bit ok;
    do_reset;
    fill_fb(1'b0);
    start_scan(ok);
    if (ok) begin
      repeat (20) @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if ({PANEL_OE, PANEL_CLK, fb_rd_en} !== 3'b100) begin
        errors++;
        $display("FAIL rst_mid_shift: got oe,clk,rd=%b, want 100", {PANEL_OE, PANEL_CLK, fb_rd_en});
      end
      @(negedge clk);
      rst = 1'b0;
      start_scan(ok);
      if (ok) begin
        checks++;
        if (fb_rd_addr !== 9'd0) begin errors++; $display("FAIL restart_addr: got %0d, want 0", fb_rd_addr); end
        run_period(0, 0, 1'b0, -1);
      end
    end
  endtask

`ifdef PANEL_BRIGHTNESS_EN
  task automatic test_brightness(input logic [7:0] b, input int periods);
    bit ok;
    brightness = b;
    do_reset;
    fill_fb(1'b0);
    start_scan(ok);
    if (ok)
      for (int i = 0; i < periods; i++) run_period(i / BITS, i % BITS, 1'b0, -1);
  endtask
`endif

  initial begin
`ifdef PANEL_BRIGHTNESS_EN
    brightness = 8'd255;
`endif
    rst = 1'b1; enable = 1'b0;
    test_reset;
    test_single_col;
    test_free_run;
    test_enable_drop;
    test_reset_mid_shift;
`ifdef PANEL_BRIGHTNESS_EN
    test_brightness(8'd127, BITS);
    test_brightness(8'd0, BITS);
    test_brightness(8'($urandom_range(1, 254)), 2*BITS);
    brightness = 8'd255;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1);
  end

endmodule
